// File: rtl/dout_event_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dout_event_receiver                                        |
// | Description : Receiving end of the SURF dout byte stream. Generates the  |
// |               phase strobe, frames EVENT_BYTES-byte events that start    |
// |               one cycle after a strobe, packs bytes little-endian into   |
// |               32-bit words and streams them out through a FWFT FIFO on   |
// |               an AXI4-Stream master with tlast on each event's last word.|
// | Options     : DOUT_RX_TIMEOUT_EN - adds a RECV idle timeout that closes  |
// |               the event with a tlast word and a sticky timeout_o flag.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dout_event_receiver #(
    parameter int EVENT_BYTES  = 12288,  // multiple of 4
    parameter int PHASE_PERIOD = 8,      // at least 2
    parameter int FIFO_DEPTH   = 16      // power of 2, at least 2
) (
    input  logic        ifclk_i,
    input  logic        ifclk_rst_i,
    input  logic        enable_i,
    output logic        dout_data_phase_o,
    input  logic [7:0]  dout_data_i,
    input  logic        dout_data_valid_i,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] event_count_o,
    output logic        align_err_o,
`ifdef DOUT_RX_TIMEOUT_EN
    output logic        timeout_o,
`endif
    output logic        overflow_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PH_W  = $clog2(PHASE_PERIOD);
    localparam int c_CNT_W = $clog2(EVENT_BYTES + 1);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(PHASE_PERIOD - 1);
    localparam logic [c_PH_W-1:0]  c_PH_ONE   = c_PH_W'(1);
    localparam logic [c_CNT_W-1:0] c_EVT_LEN  = c_CNT_W'(EVENT_BYTES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_FIFO_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_FIFO_ONE  = (c_PTR_W + 1)'(1);
`ifdef DOUT_RX_TIMEOUT_EN
    // Abort fires on the 1023rd consecutive idle cycle.
    localparam logic [9:0]         c_IDLE_ABORT = 10'd1022;
`endif

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RECV = 1'b1;

    // ------------------------------------------------------------------
    // Phase strobe
    // ------------------------------------------------------------------
    logic [c_PH_W-1:0] r_phase_cnt;
    logic              r_phase;
    logic              r_phase_d;

    // Free-running phase counter; strobe follows a zero count while enabled
    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            r_phase_cnt <= '0;
            r_phase     <= 1'b0;
            r_phase_d   <= 1'b0;
        end else begin
            if (r_phase_cnt == c_PH_LAST) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + c_PH_ONE;
            end
            r_phase   <= enable_i && (r_phase_cnt == '0);
            // r_phase_d marks the one cycle in which a start byte is legal
            r_phase_d <= r_phase;
        end
    end

    assign dout_data_phase_o = r_phase;

    // ------------------------------------------------------------------
    // Event framing and byte packing
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_byte_cnt;   // bytes received in current event; 0 in IDLE
    logic [23:0]        r_pack;       // lanes 0..2 of the word being assembled
    logic               r_wr_en;
    logic [31:0]        r_wr_data;
    logic               r_wr_last;
    logic               r_align_err;
`ifdef DOUT_RX_TIMEOUT_EN
    logic [9:0]         r_idle_cnt;
    logic               r_timeout;
`endif

    logic               w_idle;
    logic               w_start;
    logic               w_misalign;
    logic               w_accept;
    logic [1:0]         w_lane;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_evt_done;

    assign w_idle     = (r_state == c_S_IDLE);
    assign w_start    = w_idle && enable_i && dout_data_valid_i && r_phase_d;
    assign w_misalign = w_idle && enable_i && dout_data_valid_i && !r_phase_d;
    assign w_accept   = w_start || (!w_idle && dout_data_valid_i);
    assign w_lane     = r_byte_cnt[1:0];
    assign w_cnt_next = r_byte_cnt + c_CNT_ONE;
    assign w_evt_done = (w_cnt_next == c_EVT_LEN);

    // Frame the event, place bytes in lanes and stage full words for the FIFO.
    // The staging register holds the final word, so the FSM returns to IDLE on
    // the same edge that captures the last byte and the packer is free again.
    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            r_state     <= c_S_IDLE;
            r_byte_cnt  <= '0;
            r_pack      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_last   <= 1'b0;
            r_align_err <= 1'b0;
`ifdef DOUT_RX_TIMEOUT_EN
            r_idle_cnt  <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_wr_en     <= 1'b0;
            r_align_err <= w_misalign;

            if (w_accept) begin
                case (w_lane)
                    2'd0:    r_pack         <= {16'h0000, dout_data_i};
                    2'd1:    r_pack[15:8]   <= dout_data_i;
                    2'd2:    r_pack[23:16]  <= dout_data_i;
                    default: begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {dout_data_i, r_pack};
                        r_wr_last <= w_evt_done;
                    end
                endcase

                if (w_evt_done) begin
                    r_state    <= c_S_IDLE;
                    r_byte_cnt <= '0;
                end else begin
                    r_state    <= c_S_RECV;
                    r_byte_cnt <= w_cnt_next;
                end
            end

`ifdef DOUT_RX_TIMEOUT_EN
            // Idle watchdog: a stalled event is closed with a tlast word,
            // zero-padding whatever lanes were never filled.
            if (!w_idle && !dout_data_valid_i) begin
                if (r_idle_cnt == c_IDLE_ABORT) begin
                    r_idle_cnt <= '0;
                    r_wr_en    <= 1'b1;
                    r_wr_data  <= (w_lane != 2'd0) ? {8'h00, r_pack} : 32'h0000_0000;
                    r_wr_last  <= 1'b1;
                    r_timeout  <= 1'b1;
                    r_state    <= c_S_IDLE;
                    r_byte_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 10'd1;
                end
            end else begin
                r_idle_cnt <= '0;
            end
`endif
        end
    end

    assign align_err_o = r_align_err;
`ifdef DOUT_RX_TIMEOUT_EN
    assign timeout_o   = r_timeout;
`endif

    // ------------------------------------------------------------------
    // Output word FIFO (first-word-fall-through) and AXI4-Stream side
    // ------------------------------------------------------------------
    logic [32:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic [15:0]        r_event_cnt;

    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_full = (r_count == c_FIFO_FULL);
    assign w_pop  = m_axis_tvalid && m_axis_tready;
    // A simultaneous read frees a slot, so a write into a full FIFO still lands
    assign w_push = r_wr_en && (!w_full || w_pop);

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_wr_last, r_wr_data};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FIFO_ONE;
                2'b01:   r_count <= r_count - c_FIFO_ONE;
                default: r_count <= r_count;
            endcase
            // Dropped words (tlast included) leave framing intact upstream
            if (r_wr_en && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Count events as their tlast beat leaves the stream interface
    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            r_event_cnt <= '0;
        end else if (w_pop && m_axis_tlast) begin
            r_event_cnt <= r_event_cnt + 16'd1;
        end
    end

    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tlast  = r_mem[r_rd_ptr][32];
    assign m_axis_tdata  = r_mem[r_rd_ptr][31:0];
    assign overflow_o    = r_overflow;
    assign event_count_o = r_event_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dout_event_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dout_event_receiver                                     |
// | Description : Directed bench for dout_event_receiver. Instance a uses    |
// |               8-byte events with a 16-deep FIFO, instance b uses 24-byte |
// |               events with a 4-deep FIFO. Output words are checked        |
// |               against a scoreboard filled as bytes are driven.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dout_event_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       valid;
    logic       sel;      // 0 routes bytes to instance a, 1 to instance b
    logic [7:0] din;
    logic       valid_a;
    logic       valid_b;

    assign valid_a = valid && !sel;
    assign valid_b = valid && sel;

    logic        phase_a, tvalid_a, tready_a, tlast_a, align_a, ovf_a;
    logic [31:0] tdata_a;
    logic [15:0] evc_a;
    logic        phase_b, tvalid_b, tready_b, tlast_b, align_b, ovf_b;
    logic [31:0] tdata_b;
    logic [15:0] evc_b;
`ifdef DOUT_RX_TIMEOUT_EN
    logic        to_a, to_b;
`endif

    dout_event_receiver #(.EVENT_BYTES(8), .PHASE_PERIOD(8), .FIFO_DEPTH(16)) u_dut_a (
        .ifclk_i           (clk),
        .ifclk_rst_i       (rst),
        .enable_i          (en),
        .dout_data_phase_o (phase_a),
        .dout_data_i       (din),
        .dout_data_valid_i (valid_a),
        .m_axis_tdata      (tdata_a),
        .m_axis_tvalid     (tvalid_a),
        .m_axis_tready     (tready_a),
        .m_axis_tlast      (tlast_a),
        .event_count_o     (evc_a),
        .align_err_o       (align_a),
`ifdef DOUT_RX_TIMEOUT_EN
        .timeout_o         (to_a),
`endif
        .overflow_o        (ovf_a)
    );

    dout_event_receiver #(.EVENT_BYTES(24), .PHASE_PERIOD(8), .FIFO_DEPTH(4)) u_dut_b (
        .ifclk_i           (clk),
        .ifclk_rst_i       (rst),
        .enable_i          (en),
        .dout_data_phase_o (phase_b),
        .dout_data_i       (din),
        .dout_data_valid_i (valid_b),
        .m_axis_tdata      (tdata_b),
        .m_axis_tvalid     (tvalid_b),
        .m_axis_tready     (tready_b),
        .m_axis_tlast      (tlast_b),
        .event_count_o     (evc_b),
        .align_err_o       (align_b),
`ifdef DOUT_RX_TIMEOUT_EN
        .timeout_o         (to_b),
`endif
        .overflow_o        (ovf_b)
    );

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected words of an event starting at byte value 'first'; word last_idx carries tlast
    task automatic expect_words(input logic s, input logic [7:0] first, input int nwords, input int last_idx);
        logic [32:0] e;
        for (int w = 0; w < nwords; w++) begin
            e[32] = (w == last_idx);
            for (int k = 0; k < 4; k++) begin
                e[8*k +: 8] = first + 8'(4*w + k);
            end
            if (s) exp_b.push_back(e);
            else   exp_a.push_back(e);
        end
    endtask

    // Return in the cycle where the selected strobe is high
    task automatic wait_strobe(input logic s);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if ((s ? phase_b : phase_a) === 1'b1) break;
        end
        check("strobe_seen", {63'h0, (s ? phase_b : phase_a)}, 64'h1);
    endtask

    // Drive n consecutive byte values, with 'gap' idle cycles after each byte
    task automatic send(input logic s, input logic [7:0] first, input int n, input int gap);
        sel = s;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din   = first + 8'(i);
            valid = 1'b1;
            for (int g = 0; g < gap && i < n - 1; g++) begin
                @(posedge clk); #1;
                valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Scoreboard: pop and compare on every transferring beat
    always @(negedge clk) begin
        if (!rst && tvalid_a && tready_a) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL a_extra_beat: observed %0h expected no beat", {tlast_a, tdata_a});
            end else begin
                check("a_beat", {31'h0, tlast_a, tdata_a}, {31'h0, exp_a.pop_front()});
            end
        end
        if (!rst && tvalid_b && tready_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL b_extra_beat: observed %0h expected no beat", {tlast_b, tdata_b});
            end else begin
                check("b_beat", {31'h0, tlast_b, tdata_b}, {31'h0, exp_b.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int strobes;
        rst = 1'b1; en = 1'b0; valid = 1'b0; din = 8'h00; sel = 1'b0;
        tready_a = 1'b0; tready_b = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase",  {63'h0, phase_a},  64'h0);
        check("rst_tvalid", {63'h0, tvalid_a}, 64'h0);
        check("rst_tdata",  {32'h0, tdata_a},  64'h0);
        check("rst_tlast",  {63'h0, tlast_a},  64'h0);
        check("rst_evc",    {48'h0, evc_a},    64'h0);
        check("rst_align",  {63'h0, align_a},  64'h0);
        check("rst_ovf",    {63'h0, ovf_a},    64'h0);
        check("rst_tvalid_b", {63'h0, tvalid_b}, 64'h0);

        // Phase strobe: first strobe in the cycle after release, then every 8th
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check($sformatf("phase_%0d", i), {63'h0, phase_a}, {63'h0, (i % 8 == 0)});
        end

        // Aligned 8-byte event, tready high, latency of last word
        tready_a = 1'b1;
        expect_words(1'b0, 8'h01, 2, 1);
        wait_strobe(1'b0);
        send(1'b0, 8'h01, 8, 0);
        @(negedge clk);
        check("lat_n1_tvalid", {63'h0, tvalid_a}, 64'h0);
        @(negedge clk);
        check("lat_n2_tvalid", {63'h0, tvalid_a}, 64'h1);
        check("lat_n2_tlast",  {63'h0, tlast_a},  64'h1);
        check("lat_n2_tdata",  {32'h0, tdata_a},  64'h0807_0605);
        repeat (3) @(negedge clk);
        check("evc_after_1", {48'h0, evc_a}, 64'h1);

        // Byte 3 cycles after strobe in IDLE: align error, nothing written
        wait_strobe(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        din = 8'hEE; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        check("misalign_pulse", {63'h0, align_a}, 64'h1);
        @(negedge clk);
        check("misalign_end",   {63'h0, align_a}, 64'h0);
        check("misalign_nowr",  {63'h0, tvalid_a}, 64'h0);

        // Disabled: no strobes and bytes ignored without error
        en = 1'b0;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            valid = (i == 4);
            din   = 8'h99;
            if (phase_a) strobes++;
        end
        valid = 1'b0;
        @(negedge clk);
        check("dis_strobes", 64'(strobes), 64'h0);
        check("dis_align",   {63'h0, align_a}, 64'h0);
        en = 1'b1;

        // Gapped aligned event
        expect_words(1'b0, 8'h11, 2, 1);
        wait_strobe(1'b0);
        send(1'b0, 8'h11, 8, 2);
        repeat (4) @(negedge clk);
        check("evc_after_gap", {48'h0, evc_a}, 64'h2);

        // Enable dropped mid-event: the event still completes
        expect_words(1'b0, 8'h21, 2, 1);
        wait_strobe(1'b0);
        send(1'b0, 8'h21, 3, 0);
        en = 1'b0;
        send(1'b0, 8'h24, 5, 0);
        repeat (4) @(negedge clk);
        check("evc_after_endrop", {48'h0, evc_a}, 64'h3);
        en = 1'b1;

        // Overflow on instance b: 4 of 6 words kept, tail (incl. tlast) dropped
        expect_words(1'b1, 8'h30, 4, 5);
        wait_strobe(1'b1);
        send(1'b1, 8'h30, 24, 0);
        repeat (3) @(negedge clk);
        check("ovf_set",      {63'h0, ovf_b},    64'h1);
        check("ovf_tvalid",   {63'h0, tvalid_b}, 64'h1);
        check("ovf_head_held", {32'h0, tdata_b}, 64'h3332_3130);
        @(posedge clk); #1;
        tready_b = 1'b1;
        repeat (8) @(negedge clk);
        check("ovf_sticky",   {63'h0, ovf_b},    64'h1);
        check("ovf_evc",      {48'h0, evc_b},    64'h0);
        check("ovf_drained",  {63'h0, tvalid_b}, 64'h0);
        check("ovf_sb_empty", 64'(exp_b.size()), 64'h0);

        // Framing preserved after the drop
        expect_words(1'b1, 8'h60, 6, 5);
        wait_strobe(1'b1);
        send(1'b1, 8'h60, 24, 0);
        repeat (4) @(negedge clk);
        check("ovf_next_evc", {48'h0, evc_b}, 64'h1);

        // Reset after 5 bytes: partial event discarded
        tready_a = 1'b0;
        wait_strobe(1'b0);
        send(1'b0, 8'h41, 5, 0);
        @(negedge clk);
        check("mid_word_held", {63'h0, tvalid_a}, 64'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_tvalid", {63'h0, tvalid_a}, 64'h0);
        check("mid_rst_evc",    {48'h0, evc_a},    64'h0);
        check("mid_rst_ovf_b",  {63'h0, ovf_b},    64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        tready_a = 1'b1;
        expect_words(1'b0, 8'h51, 2, 1);
        wait_strobe(1'b0);
        send(1'b0, 8'h51, 8, 0);
        repeat (4) @(negedge clk);
        check("post_rst_evc", {48'h0, evc_a}, 64'h1);

`ifdef DOUT_RX_TIMEOUT_EN
        // 6 bytes then silence: zero-padded tlast word after the idle timeout
        check("to_clear", {63'h0, to_a}, 64'h0);
        exp_a.push_back({1'b0, 32'h0403_0201});
        exp_a.push_back({1'b1, 32'h0000_0605});
        wait_strobe(1'b0);
        send(1'b0, 8'h01, 6, 0);
        repeat (1030) @(negedge clk);
        check("to_set", {63'h0, to_a}, 64'h1);
        check("to_evc", {48'h0, evc_a}, 64'h2);
`endif

        repeat (4) @(negedge clk);
        check("sb_a_empty", 64'(exp_a.size()), 64'h0);
        check("sb_b_empty", 64'(exp_b.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dout_event_receiver.md
Name: dout_event_receiver

Overview:
- Receiving end of the SURF dout byte stream produced by the event buffer; used in loopback test builds and in the downstream collector.
- Drives the dout phase strobe, captures 8-bit dout data and frames each event of EVENT_BYTES bytes.
- Packs bytes little-endian into 32-bit words and presents them on an AXI4-Stream master with tlast on each event's final word.
- Single ifclk domain; sits directly on the dout_data_o / dout_data_valid_o / dout_data_phase_i pins of the SURF wrapper.

Parameters:
- EVENT_BYTES, 12288, bytes per event; must be a multiple of 4.
- PHASE_PERIOD, 8, ifclk cycles between phase strobes; must be at least 2.
- FIFO_DEPTH, 16, output word FIFO depth; must be a power of 2.

Ports:
- ifclk_i  in  1  interface clock; every port is synchronous to it.
- ifclk_rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  enables phase strobing and event capture.
- dout_data_phase_o  out  1  phase strobe to the transmitter.
- dout_data_i  in  8  dout byte.
- dout_data_valid_i  in  1  dout byte qualifier.
- m_axis_tdata  out  32  packed word; byte 0 is in bits [7:0].
- m_axis_tvalid  out  1  AXI4-Stream valid.
- m_axis_tready  in  1  AXI4-Stream ready.
- m_axis_tlast  out  1  marks the final word of an event.
- event_count_o  out  16  count of completed events; wraps at 16 bits.
- align_err_o  out  1  one-cycle pulse on a misaligned start byte.
- overflow_o  out  1  sticky FIFO-overflow flag.

Behaviour:
Reset:
- Synchronous, active-high; all outputs reset to 0.
- Clears the phase counter, packer, byte counter and FIFO; state goes to IDLE.
- A reset mid-event discards the partial event with no tlast emitted.

Phase counter:
- Free-runs 0 to PHASE_PERIOD-1 and wraps.
- dout_data_phase_o is registered and is 1 on the cycle after the counter equals 0, only while enable_i=1; otherwise it is 0.

IDLE:
- A valid byte is a start byte only if it arrives exactly 1 cycle after dout_data_phase_o was high.
- Aligned start byte: it is byte 0; byte counter = 1; go to RECV.
- Any other valid byte in IDLE: discarded and align_err_o pulses for 1 cycle.
- Valid bytes are ignored entirely while enable_i=0.

RECV:
- Each valid byte is placed in lane (byte counter mod 4); the byte counter then increments. Gaps in dout_data_valid_i are allowed.
- When lane 3 is filled, the word is written to the FIFO on the next cycle. tlast=1 if the byte counter has reached EVENT_BYTES.
- After the tlast word is written, return to IDLE.
- Deasserting enable_i mid-event does not abort; the current event completes.

FIFO and output:
- First-word-fall-through.
- Latency: the word's lane-3 byte is sampled in cycle N; the word is written in N+1; m_axis_tvalid is high in N+2 if the FIFO was empty.
- A beat transfers only when tvalid and tready are both 1.
- tdata and tlast are held stable while tvalid=1 and tready=0.
- FIFO full at write time: the word is dropped (including a tlast word) and overflow_o sets. overflow_o stays set until reset. Byte counting continues so that framing is preserved.
- Write and read in the same cycle while full: the write succeeds, no overflow.

Event counter:
- event_count_o increments when a tlast beat transfers on the output.
- Wraps from 0xFFFF to 0x0000.

Optional Feature:
Macro DOUT_RX_TIMEOUT_EN.
- When defined: in RECV, a 10-bit idle counter counts cycles with no valid byte and clears on each valid byte.
- When it reaches 1023, the event is aborted:
  - The partial word is written with unfilled lanes zero and tlast=1.
  - If no partial word is pending, a zero word with tlast=1 is written.
  - Sticky output timeout_o (1 bit, resets to 0) sets.
  - State returns to IDLE.
- When undefined: no timeout_o port exists, and RECV waits indefinitely for bytes.

Test Plan:
- Reset, then enable_i=1, PHASE_PERIOD=8 -> dout_data_phase_o high on every 8th cycle, first strobe on cycle 1 after reset release.
- EVENT_BYTES=8: bytes 01..08 aligned after the strobe, tready=1 -> words 0x04030201 then 0x08070605; tlast on the second word; the second word's tvalid appears 2 cycles after byte 08; event_count_o=1.
- A byte arrives 3 cycles after the strobe in IDLE -> align_err_o pulses once, no FIFO write; the next aligned event is received correctly.
- FIFO_DEPTH=4, tready=0, EVENT_BYTES=24 -> 4 words held, words 5 and 6 dropped, overflow_o=1 and stays 1 after tready rises; event_count_o unchanged.
- Assert ifclk_rst_i after 5 bytes of an event -> m_axis_tvalid=0 and event_count_o=0 on the next cycle; the following aligned event is received complete.
- With DOUT_RX_TIMEOUT_EN: send 6 bytes then stop -> after 1023 idle cycles the word 0x0000_0605 is output with tlast=1, timeout_o=1, event_count_o increments when that beat transfers.
